// File: rtl/cache_refill_ctrl_if.sv
// Bundles the miss, backing-memory and cache-fill signals of the refill engine.
// The refill engine takes the slave view; the surrounding cache/memory side takes master.
interface cache_refill_ctrl_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  miss_valid;
    logic [ADDR_WIDTH-1:0] miss_address;
    logic                  miss_ready;
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  fill_enablewrite;
    logic [ADDR_WIDTH-1:0] fill_address;
    logic [DATA_WIDTH-1:0] fill_datain;
    logic [1:0]            fill_writebyte;
    logic                  fill_done;
    logic                  fill_error;

    modport master (
        output miss_valid, miss_address, mem_ack, mem_rdata,
        input  miss_ready, mem_req, mem_addr,
        input  fill_enablewrite, fill_address, fill_datain, fill_writebyte,
        input  fill_done, fill_error
    );

    modport slave (
        input  miss_valid, miss_address, mem_ack, mem_rdata,
        output miss_ready, mem_req, mem_addr,
        output fill_enablewrite, fill_address, fill_datain, fill_writebyte,
        output fill_done, fill_error
    );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Miss-refill engine: fetches a 4-byte line one byte at a time from backing memory
// and writes each byte into the cache, pulsing done on success or error on timeout.
module cache_refill_ctrl #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic              clk,
    input logic              reset,
    cache_refill_ctrl_if.slave bus
);
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WRITE,
        DONE,
        ERR
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   line_q, line_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [ADDR_WIDTH-1:0]   byte_addr;

    assign byte_addr = line_q | {{(ADDR_WIDTH-2){1'b0}}, cnt_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            line_q  <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            data_q  <= data_d;
        end
    end

    // Outputs decode from state only, so reset drops mem_req without waiting for a clock.
    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        data_d  = data_q;

        bus.miss_ready       = 1'b0;
        bus.mem_req          = 1'b0;
        bus.mem_addr         = '0;
        bus.fill_enablewrite = 1'b0;
        bus.fill_address     = '0;
        bus.fill_datain      = '0;
        bus.fill_writebyte   = '0;
        bus.fill_done        = 1'b0;
        bus.fill_error       = 1'b0;

        case (state_q)
            IDLE: begin
                bus.miss_ready = 1'b1;
                if (bus.miss_valid) begin
                    line_d  = bus.miss_address & ~ADDR_WIDTH'(3);
                    cnt_d   = '0;
                    timer_d = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = byte_addr;
                // An ack arriving on the final allowed cycle still completes the byte.
                if (bus.mem_ack) begin
                    data_d  = bus.mem_rdata;
                    timer_d = '0;
                    state_d = WRITE;
                end else if (timer_q == TIMER_LAST) begin
                    timer_d = '0;
                    state_d = ERR;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WRITE: begin
                bus.fill_enablewrite = 1'b1;
                bus.fill_address     = byte_addr;
                bus.fill_datain      = data_q;
                bus.fill_writebyte   = cnt_q;
                if (cnt_q == 2'd3) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = REQ;
                end
            end
            DONE: begin
                bus.fill_done = 1'b1;
                state_d       = IDLE;
            end
            ERR: begin
                bus.fill_error = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
